fir_decimator: RTL and testbench
================================

# fir_decimator

Output stage placed directly after the 4-tap FIR filter. It takes the filter's 32-bit signed result stream and keeps one sample in every `DEC`. Each kept sample is rounded and scaled down to 16 bits, buffered in a small FIFO, and offered to the consumer over a valid/ready handshake. It absorbs the rate and width mismatch between the free-running filter and slower downstream logic.

## Interface
- `DW_IN`, 32, input sample width (signed)
- `DW_OUT`, 16, output sample width (signed), < `DW_IN`
- `SHIFT`, 4, arithmetic right shift applied before narrowing, 0..`DW_IN`-`DW_OUT`
- `DEC`, 4, decimation factor, ≥1
- `DEPTH`, 8, FIFO entries, power of 2, ≥2
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  `in_data` holds a new filter sample this cycle
- `in_data`  in  `DW_IN`  signed filter output sample
- `out_valid`  out  1  FIFO head is available
- `out_ready`  in  1  consumer accepts the head this cycle
- `out_data`  out  `DW_OUT`  signed FIFO head sample
- `level`  out  clog2(`DEPTH`)+1  current FIFO occupancy
- `drop`  out  1  one-cycle pulse: a scaled sample was discarded because the FIFO was full
- `sat`  out  1  one-cycle pulse: a sample was clipped (only meaningful with `FIR_DEC_SAT_EN`)

## Operation
- **Reset values:** `out_valid`=0, `out_data`=0, `level`=0, `drop`=0, `sat`=0; phase counter=0; stage-1 valid=0; FIFO pointers=0.
- **Phase counter:** runs 0..`DEC`-1 and advances only on `in_valid`, wrapping to 0.
  - A sample is kept when `in_valid`=1 and phase=0, so the first sample after reset is kept.
  - Cycles with `in_valid`=0 do not advance the phase.
  - With `DEC`=1 every valid sample is kept.
- **Scale stage (registered):**
  - `t` = `in_data` + (`SHIFT`>0 ? 1<<(`SHIFT`-1) : 0), computed in `DW_IN`+1 bits so the rounding add cannot wrap.
  - `t` is then shifted arithmetically right by `SHIFT`. Rounding is half toward +inf.
  - Narrowing of the shifted value to `DW_OUT` is set by the build option (see Configuration).
- **FIFO:**
  - First-word-fall-through; `out_data` shows the head whenever `out_valid`=1.
  - Write happens when stage-1 valid=1.
  - Read happens when `out_valid` && `out_ready`.
  - `out_ready` while empty has no effect.
  - `out_data` holds its last value when the FIFO is empty.
- **Full with a write pending:**
  - If a read also occurs that cycle, the write is accepted and `level` stays at `DEPTH`.
  - Otherwise the sample is discarded, `drop`=1 for one cycle, and FIFO contents are unchanged.
- **Empty with a write:** a simultaneous read is impossible because `out_valid`=0. The write makes the sample visible on the next cycle.
- **Mid-operation reset:** all FIFO contents and the in-flight stage-1 sample are lost, the phase returns to 0, and outputs take their reset values immediately.

## Timing
- Latency from a kept `in_valid` at edge n:
  - The scale register loads at edge n.
  - The FIFO write happens at edge n+1.
  - `out_valid`=1 from edge n+1 onward, i.e. visible in the cycle after n+1, when the FIFO was empty.
- `level` updates on the same edge as the write or read.
- Sustained throughput: one output per cycle. Input rate is up to one sample per cycle.
- `sat` and `drop` are registered pulses:
  - `sat` is asserted the cycle after the scale register loads.
  - `drop` is asserted the cycle after the refused write.
- The handshake uses no combinational path from `out_ready` to `out_valid`.

## Configuration
- **`FIR_DEC_SAT_EN` defined:** a shifted value above 2^(`DW_OUT`-1)-1 becomes that maximum, and one below -2^(`DW_OUT`-1) becomes that minimum. `sat` pulses for every clipped sample.
- **`FIR_DEC_SAT_EN` undefined:** the low `DW_OUT` bits are taken (two's-complement wrap), `sat` is tied to 0, and no comparators are built.

## Test plan
- **Decimation and rounding** (`DEC`=4, `SHIFT`=4): drive `in_data`=24, 0, 0, 0, -24, 0, 0, 0 with `in_valid`=1 and `out_ready`=1. Expect exactly two outputs, 2 then -1, with the first `out_valid` two edges after the first input.
- **Idle cycles:** repeat the previous test with `in_valid`=0 on alternate cycles. Expect identical output values; the phase advances only on valid cycles.
- **Saturation** (`FIR_DEC_SAT_EN`): drive `in_data`=1048576. Expect `out_data`=32767 and `sat` pulsing once. Drive -1048576: expect -32768. Without the macro, 1048576 gives 0 and `sat` stays 0.
- **Full and drop** (`DEC`=1, `DEPTH`=8): hold `out_ready`=0 and feed 10 valid samples 16, 32, ... Expect `level`=8, two `drop` pulses, and the head equal to 1 (16>>4 rounded). Then a full-plus-simultaneous-read cycle is accepted with no `drop`.
- **Drain order:** after the full test, set `out_ready`=1. Expect 1, 2, ..., 8 in order, `level` reaching 0, and `out_valid` falling the cycle after the last read.
- **Mid-run reset:** assert `reset` while `level`=5. Expect `out_valid`=0 and `level`=0 immediately. After release, the first valid input is kept (phase=0).

Source files
------------

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - decimate, round/scale and FIFO-buffer a FIR sample stream
//
// Keeps one valid input sample in every DEC. Each kept sample is rounded
// (half toward +inf), arithmetically shifted right by SHIFT and narrowed to
// DW_OUT bits. The result is queued in a DEPTH-entry first-word-fall-through
// FIFO and offered to the consumer with a valid/ready handshake.
//
// Build option: FIR_DEC_SAT_EN - clip to the DW_OUT signed range and pulse
// sat; when undefined the low DW_OUT bits are kept (wrap) and sat is 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   in_data holds a new filter sample
//   in_data    in   DW_IN-bit signed filter sample
//   out_valid  out  FIFO head available
//   out_ready  in   consumer takes the head this cycle
//   out_data   out  DW_OUT-bit signed FIFO head (holds last value when empty)
//   level      out  FIFO occupancy, 0..DEPTH
//   drop       out  one-cycle pulse: a scaled sample was refused by a full FIFO
//   sat        out  one-cycle pulse: a kept sample was clipped
module fir_decimator #(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 16,
  parameter int SHIFT  = 4,
  parameter int DEC    = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DW_IN-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW_OUT-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop,
  output logic                     sat
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DEC - 1);
  // Half an output LSB; (1<<SHIFT)>>1 is zero when SHIFT is zero.
  localparam logic signed [DW_IN:0] RND = (DW_IN + 1)'((1 << SHIFT) >> 1);

  // ---------------------------------------------------------------- phase
  logic [PW-1:0] phase;
  logic          keep;

  assign keep = in_valid && (phase == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    end
  end

  // ---------------------------------------------------------------- scale
  // One extra bit so the rounding add cannot wrap.
  logic signed [DW_IN:0] rounded;
  logic [DW_OUT-1:0]     narrowed;

  assign rounded = $signed({in_data[DW_IN-1], in_data}) + RND;

`ifdef FIR_DEC_SAT_EN
  localparam logic signed [DW_IN:0] OUT_MAX = {{(DW_IN - DW_OUT + 2){1'b0}}, {(DW_OUT - 1){1'b1}}};
  localparam logic signed [DW_IN:0] OUT_MIN = {{(DW_IN - DW_OUT + 2){1'b1}}, {(DW_OUT - 1){1'b0}}};

  logic signed [DW_IN:0] shifted;
  logic                  clipped;
  logic                  sat_q;

  assign shifted = rounded >>> SHIFT;

  always_comb begin
    clipped  = 1'b0;
    narrowed = shifted[DW_OUT-1:0];
    if (shifted > OUT_MAX) begin
      clipped  = 1'b1;
      narrowed = {1'b0, {(DW_OUT - 1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      clipped  = 1'b1;
      narrowed = {1'b1, {(DW_OUT - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= keep && clipped;
    end
  end

  assign sat = sat_q;
`else
  // Two's-complement wrap: only the low DW_OUT bits survive.
  assign narrowed = DW_OUT'(rounded >>> SHIFT);
  assign sat      = 1'b0;
`endif

  // --------------------------------------------------------- stage-1 reg
  logic              s1_valid;
  logic [DW_OUT-1:0] s1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data <= narrowed;
      end
    end
  end

  // ----------------------------------------------------------------- FIFO
  logic [DW_OUT-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic              full;
  logic              rd_en;
  logic              wr_en;

  // out_valid comes straight from the occupancy register, so out_ready has
  // no combinational path to it.
  assign out_valid  = (count != '0);
  assign level      = count;
  assign full       = (count == (AW + 1)'(DEPTH));
  assign rd_en      = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en      = s1_valid && (!full || rd_en);
  assign rd_ptr_nxt = rd_en ? rd_ptr + AW'(1) : rd_ptr;
  assign count_nxt  = count + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      drop     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      drop   <= s1_valid && full && !rd_en;
      // out_data is a registered copy of the next head. When the incoming
      // word lands exactly at the next head slot (FIFO empty, or its last
      // entry leaving) it bypasses the memory. An empty FIFO keeps the
      // previous value.
      if (count_nxt != '0) begin
        out_data <= (wr_en && (wr_ptr == rd_ptr_nxt)) ? s1_data : mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - self-checking bench for fir_decimator
module tb_fir_decimator;

  localparam int DW_IN  = 32;
  localparam int DW_OUT = 16;
  localparam int SHIFT  = 4;
  localparam int DEC    = 4;
  localparam int DEPTH  = 8;
  localparam longint HALF    = 8;
  localparam longint DIVISOR = 16;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DW_IN-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW_OUT-1:0] out_data;
  logic [3:0]        level;
  logic              drop;
  logic              sat;

  fir_decimator #(
    .DW_IN(DW_IN), .DW_OUT(DW_OUT), .SHIFT(SHIFT), .DEC(DEC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop(drop), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference state: queue of FIFO contents, one pending scaled sample,
  // sample index modulo DEC, and the last head shown on out_data
  logic [15:0] mq[$];
  logic [15:0] got_q[$];
  bit          m_pend_v;
  logic [15:0] m_pend;
  int          m_phase;
  logic [15:0] m_last;
  int          drops_seen;
  int          sats_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // floor((x + 2^(SHIFT-1)) / 2^SHIFT), then clip or wrap to 16 bits
  function automatic logic [15:0] scale(input logic [31:0] x, output bit clip);
    longint num;
    longint q;
    num = longint'($signed(x)) + HALF;
    q = num / DIVISOR;
    if ((num % DIVISOR) != 0 && num < 0) q = q - 1;
    clip = 1'b0;
`ifdef FIR_DEC_SAT_EN
    if (q > 32767) begin
      q = 32767;
      clip = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      clip = 1'b1;
    end
`endif
    return q[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend_v = 1'b0;
    m_pend   = '0;
    m_phase  = 0;
    m_last   = '0;
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input bit iv, input logic [31:0] id, input bit rdy);
    bit          e_drop;
    bit          e_sat;
    bit          clip;
    logic [15:0] v;
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    if (rdy && mq.size() != 0) begin
      v = mq.pop_front();
      got_q.push_back(v);
    end
    e_drop = 1'b0;
    if (m_pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend);
      else e_drop = 1'b1;
    end
    e_sat    = 1'b0;
    m_pend_v = iv && (m_phase == 0);
    if (m_pend_v) begin
      m_pend = scale(id, clip);
      e_sat  = clip;
    end
    if (iv) m_phase = (m_phase + 1) % DEC;
    @(posedge clk);
    #1;
    if (mq.size() != 0) m_last = mq[0];
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("level", 32'(level), 32'(mq.size()));
    check("drop", 32'(drop), 32'(e_drop));
    check("sat", 32'(sat), 32'(e_sat));
    check("out_data", 32'(out_data), 32'(m_last));
    if (drop) drops_seen++;
    if (sat) sats_seen++;
  endtask

  initial begin
    int thr;
    int x;
    checks     = 0;
    failures   = 0;
    drops_seen = 0;
    sats_seen  = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    reset = 1'b0;

    // decimation and rounding: 24 -> 2, -24 -> -1
    got_q.delete();
    step(1'b1, 32'd24, 1'b1);
    check("lat_first_edge", 32'(out_valid), 32'd0);
    step(1'b1, 32'd0, 1'b1);
    check("lat_second_edge", 32'(out_valid), 32'd1);
    step(1'b1, 32'd0, 1'b1);
    step(1'b1, 32'd0, 1'b1);
    step(1'b1, -32'sd24, 1'b1);
    repeat (3) step(1'b1, 32'd0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1);
    check("dec_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("dec_first", 32'(got_q[0]), 32'h0002);
      check("dec_second", 32'(got_q[1]), 32'hFFFF);
    end

    // idle cycles between valid samples must not advance the phase
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0) ? 32'd24 : (i == 4) ? -32'sd24 : 32'd0, 1'b1);
      step(1'b0, $urandom, 1'b1);
    end
    repeat (3) step(1'b0, 32'd0, 1'b1);
    check("idle_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("idle_first", 32'(got_q[0]), 32'h0002);
      check("idle_second", 32'(got_q[1]), 32'hFFFF);
    end

    // large magnitudes: clip or wrap depending on the build
    got_q.delete();
    sats_seen = 0;
    step(1'b1, 32'd1048576, 1'b1);
    repeat (3) step(1'b1, 32'd0, 1'b1);
    step(1'b1, -32'sd1048576, 1'b1);
    repeat (3) step(1'b1, 32'd0, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1);
    check("big_count", 32'(got_q.size()), 32'd2);
`ifdef FIR_DEC_SAT_EN
    if (got_q.size() >= 2) begin
      check("big_pos", 32'(got_q[0]), 32'h7FFF);
      check("big_neg", 32'(got_q[1]), 32'h8000);
    end
    check("sat_pulses", 32'(sats_seen), 32'd2);
`else
    if (got_q.size() >= 2) begin
      check("big_pos", 32'(got_q[0]), 32'h0000);
      check("big_neg", 32'(got_q[1]), 32'h0000);
    end
    check("sat_pulses", 32'(sats_seen), 32'd0);
`endif

    // fill to DEPTH with the consumer stalled; two kept samples get dropped
    got_q.delete();
    drops_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 32'(16 * k), 1'b0);
      repeat (3) step(1'b1, $urandom, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0);
    check("full_level", 32'(level), 32'd8);
    check("full_drops", 32'(drops_seen), 32'd2);
    check("full_head", 32'(out_data), 32'd1);
    // full FIFO, write pending, head leaving: accepted, no drop
    drops_seen = 0;
    step(1'b1, 32'd176, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    check("full_rd_level", 32'(level), 32'd8);
    check("full_rd_drop", 32'(drops_seen), 32'd0);

    // drain order
    repeat (10) step(1'b0, 32'd0, 1'b1);
    check("drain_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      check("drain_order", 32'(got_q[i]), (i < 8) ? 32'(i + 1) : 32'd11);
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // randomized traffic with varying back-pressure
    for (int blk = 0; blk < 4; blk++) begin
      thr = (blk == 0) ? 2 : (blk == 1) ? 5 : (blk == 2) ? 9 : 10;
      for (int n = 0; n < 120; n++) begin
        if ($urandom_range(0, 3) == 0) x = int'($urandom);
        else x = int'($urandom_range(0, 2000000)) - 1000000;
        step($urandom_range(0, 3) != 0, 32'(x), $urandom_range(0, 9) < thr);
      end
    end

    // mid-run reset with five entries buffered
    repeat (12) step(1'b0, 32'd0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      if (mq.size() + int'(m_pend_v) >= 5) break;
      step(1'b1, $urandom, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_drop", 32'(drop), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    step(1'b1, 32'd160, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1);
    check("post_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) check("post_rst_first", 32'(got_q[0]), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
